// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_arb_pkg                                               |
// | Brief   : Shared encodings and helpers for the data-memory arbiter.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dmem_arb_pkg;

  // Access size encodings carried on req_size (3 is reserved and behaves as word).
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Requester indices.
  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Byte and half accesses are narrower than the memory word.
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_lane_align                                            |
// | Brief   : Combinational byte-lane steering: store merge into a read  |
// |           word and load lane extraction with sign/zero extension.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dmem_lane_align
  import dmem_arb_pkg::*;
(
  input  logic [31:0] rd_q,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane picked by both low address bits, half lane by bit 1 only.
  assign w_byte = rd_q[{lo, 3'b000} +: 8];
  assign w_half = rd_q[{lo[1], 4'b0000} +: 16];

  // Replace the addressed lane(s) of the old word with the right-aligned store data.
  always_comb begin
    merged = wdata;
    case (size)
      SZ_BYTE: begin
        merged = rd_q;
        merged[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        merged = rd_q;
        merged[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  // Right-align the addressed lane and extend it to a full word.
  always_comb begin
    load_data = rd_q;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: load_data = is_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: load_data = rd_q;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_arbiter                                               |
// | Brief   : Round-robin arbiter sharing a word-only single-port data   |
// |           memory between the LSU (port 0) and DMA/debug (port 1),    |
// |           adding sub-word loads and read-modify-write stores.        |
// | Options : DMEM_ARB_MISALIGN_CHK_EN - misaligned half/word accesses   |
// |           skip memory and complete with rsp_err=1.                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [3:0]          req_size,
  input  logic [1:0]          req_unsigned,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_re,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t              r_state;
  logic                r_rr_last;
  logic                r_port;
  logic                r_we;
  logic                r_uns;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_q;
  logic [1:0]          r_rsp_valid;

  logic                w_gnt;
  logic                w_fire;
  logic                w_we;
  logic                w_uns;
  logic [1:0]          w_size;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_misalign;
  logic                w_rsp_err;
  logic [1:0]          w_port_oh;
  logic                w_in_resp;
  logic                w_mem_phase;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_load_data;

  // Pick the winner: a lone requester wins outright, contention goes to the port not served last.
  always_comb begin
    w_gnt = PORT_LSU;
    if (req_valid == 2'b11) w_gnt = ~r_rr_last;
    else if (req_valid[1])  w_gnt = PORT_DMA;
  end

  assign w_fire    = !reset && (r_state == ST_IDLE) && (req_valid != 2'b00);
  assign req_ready = w_fire ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  assign w_we    = w_gnt ? req_we[1]                    : req_we[0];
  assign w_uns   = w_gnt ? req_unsigned[1]              : req_unsigned[0];
  assign w_size  = w_gnt ? req_size[3:2]                : req_size[1:0];
  assign w_addr  = w_gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign w_wdata = w_gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  assign w_port_oh = r_port ? 2'b10 : 2'b01;

  // Main sequencer: latch the granted request, run read and/or write, then pulse the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_last   <= PORT_DMA;
      r_port      <= PORT_LSU;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= SZ_BYTE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_q      <= '0;
      r_rsp_valid <= 2'b00;
    end else begin
      r_rsp_valid <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_port    <= w_gnt;
            r_rr_last <= w_gnt;
            r_we      <= w_we;
            r_uns     <= w_uns;
            r_size    <= w_size;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            if (w_misalign) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= req_ready;
            end else if (!w_we || is_subword(w_size)) begin
              r_state <= ST_RD;
            end else begin
              r_state <= ST_WR;
            end
          end
        end
        ST_RD: begin
          r_rd_q <= mem_rdata;
          if (r_we) begin
            r_state <= ST_WR;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= w_port_oh;
          end
        end
        ST_WR: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= w_port_oh;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  logic r_rsp_err;

  assign w_misalign = is_misaligned(w_size, w_addr[1:0]);

  // Error flag raised on a misaligned accept and dropped once its response slot ends.
  always_ff @(posedge clk) begin
    if (reset)                     r_rsp_err <= 1'b0;
    else if (w_fire)               r_rsp_err <= w_misalign;
    else if (r_state == ST_RESP)   r_rsp_err <= 1'b0;
  end

  assign w_rsp_err = r_rsp_err;
`else
  assign w_misalign = 1'b0;
  assign w_rsp_err  = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .rd_q        (r_rd_q),
    .wdata       (r_wdata),
    .size        (r_size),
    .lo          (r_addr[1:0]),
    .is_unsigned (r_uns),
    .merged      (w_merged),
    .load_data   (w_load_data)
  );

  assign w_in_resp   = !reset && (r_state == ST_RESP);
  assign w_mem_phase = (r_state == ST_RD) || (r_state == ST_WR);

  // Memory strobes are gated by reset so an abandoned access never reaches the array.
  assign mem_re    = !reset && (r_state == ST_RD);
  assign mem_we    = !reset && (r_state == ST_WR);
  assign mem_addr  = w_mem_phase ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = (r_state == ST_WR) ? w_merged : '0;

  assign rsp_valid = reset ? 2'b00 : r_rsp_valid;
  assign rsp_err   = w_in_resp && w_rsp_err;
  assign rsp_rdata = (w_in_resp && !r_we && !w_rsp_err) ? w_load_data : '0;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters. Port 0 is the core load/store unit; port 1 is the DMA/debug loader.
- Round-robin arbitration over a valid/ready request handshake and a one-cycle response pulse.
- Sequences memory accesses and adds sub-word loads (sign/zero extended) and sub-word stores (read-modify-write) on top of the memory's word-only interface.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port accept; one-hot or zero
- req_we  in  2  per-port 1=store, 0=load
- req_size  in  4  2 bits per port: 0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_unsigned  in  2  per-port load zero-extend
- req_addr  in  2*ADDR_W  per-port byte address
- req_wdata  in  64  per-port store data, right-aligned
- rsp_valid  out  2  per-port one-cycle completion pulse
- rsp_rdata  out  32  extended load data, shared by both ports; qualify with rsp_valid
- rsp_err  out  1  error flag with rsp_valid; driven 0 unless the optional feature is compiled in
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  memory write word
- mem_rdata  in  32  memory read word; updated at negedge while mem_re=1

Behaviour:
- Reset (sync, clk, active-high):
  - state=IDLE, rr_last=1 so port 0 wins first.
  - All outputs 0, latched request cleared.
  - mem_re/mem_we are combinationally gated by !reset, so no memory access occurs in a reset cycle.
  - Reset mid-operation abandons the access; no rsp_valid is produced.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - If any req_valid is set: grant one port, assert req_ready[g] combinationally, and latch we/size/unsigned/addr/wdata/g at posedge.
  - Both valid: grant the port != rr_last. rr_last updates on grant.
  - Next state: load -> RD; word store -> WR; byte/half store -> RD (RMW).
- RD:
  - mem_re=1, mem_addr=aligned address.
  - Capture mem_rdata into rd_q at the posedge ending RD.
  - Next: load -> RESP; store -> WR.
- WR:
  - mem_we=1.
  - mem_wdata = full word, or rd_q with the selected lane(s) replaced by wdata[7:0] / wdata[15:0].
  - Lane selection: byte lane = addr[1:0]; half uses addr[1].
  - Next: RESP.
- RESP:
  - rsp_valid[g]=1 for one cycle.
  - rsp_rdata = selected lane, sign- or zero-extended per req_unsigned; word = rd_q.
  - rsp_rdata=0 for stores.
  - Next: IDLE. No request is accepted in RESP.
- Latency from the accept cycle (cycle 0):
  - Load, and word store: rsp in cycle 2.
  - Sub-word store: rsp in cycle 3.
  - Throughput is one transaction per 3 or 4 cycles.
- Misalignment (feature absent):
  - Word: addr[1:0] ignored.
  - Half: addr[0] ignored.
- Requesters hold request fields stable until req_ready.
- No response backpressure: the requester must take rsp_valid.
- mem_addr is driven 0 outside RD/WR.

Optional Feature:
- Macro: DMEM_ARB_MISALIGN_CHK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE -> RESP directly.
  - No mem_re/mem_we is issued.
  - rsp_err=1 and rsp_rdata=0.
- Undefined: the rsp_err port still exists, tied 0; low address bits are ignored as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state encodings ST_IDLE, ST_RD, ST_WR, ST_RESP;
  - port indices PORT_LSU=0, PORT_DMA=1.
- Sub-module dmem_lane_align, purely combinational:
  - store merge (rd_q, wdata, size, addr[1:0]) -> merged word;
  - load extract/extend (rd_q, size, addr[1:0], unsigned) -> rsp_rdata.

Test Plan:
- Preload word 0x8001_7F80 at 0x10. Port0 lb at 0x10 -> rsp_rdata 0xFFFF_FF80. lbu at 0x11 -> 0x0000_007F. lh at 0x12 -> 0xFFFF_8001. rsp_valid at cycle 2 after accept.
- Port1 sw 0xDEAD_BEEF at 0x20 -> mem_we one cycle with mem_addr 0x20. Then lw 0x20 -> 0xDEAD_BEEF.
- sb 0xAA at 0x21 over 0x1122_3344 -> mem_re then mem_we cycles. Memory holds 0x1122_AA44. rsp at cycle 3.
- Both ports valid continuously for 4 transactions -> grants alternate 0,1,0,1. req_ready is never asserted to both ports.
- Reset asserted during the WR cycle of an sw -> mem_we=0 that cycle, no rsp_valid. Next request grants port 0.
- With DMEM_ARB_MISALIGN_CHK_EN defined: lw at 0x22 -> rsp_err=1 at cycle 1, mem_re never asserted. Without the macro: same access returns the word at 0x20.
